// File: rtl/timestep_scheduler_pkg.sv
// Shared definitions for the timestep scheduler: FSM encoding, spike-flit field
// positions and the neuron-bank register offsets.
package timestep_scheduler_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitBus,
    StUpdate,
    StRead,
    StSend,
    StDone
  } sched_state_e;

  // Spike flit layout (LSB of each field)
  localparam int unsigned PktDestXLsb = 28;
  localparam int unsigned PktDestYLsb = 24;
  localparam int unsigned PktSrcXLsb  = 20;
  localparam int unsigned PktSrcYLsb  = 16;
  localparam int unsigned PktIdxLsb   = 8;
  localparam int unsigned PktTsLsb    = 0;

  localparam logic [31:0] DefaultStepOff  = 32'h0;
  localparam logic [31:0] DefaultSpikeOff = 32'h4;

  function automatic logic [31:0] neuron_addr(input logic [31:0] base,
                                               input logic [31:0] stride,
                                               input logic [7:0]  idx,
                                               input logic [31:0] off);
    return base + stride * {24'h0, idx} + off;
  endfunction

endpackage

// File: rtl/timestep_scheduler_spike_pkt_builder.sv
// Combinational spike-flit formatter: destination, source, neuron index and
// low byte of the timestep.
module timestep_scheduler_spike_pkt_builder
  import timestep_scheduler_pkg::*;
(
  input  logic [3:0]  dest_x_i,
  input  logic [3:0]  dest_y_i,
  input  logic [3:0]  src_x_i,
  input  logic [3:0]  src_y_i,
  input  logic [7:0]  idx_i,
  input  logic [7:0]  ts_i,
  output logic [31:0] flit_o
);

  always_comb begin
    flit_o = '0;
    flit_o[PktDestXLsb +: 4] = dest_x_i;
    flit_o[PktDestYLsb +: 4] = dest_y_i;
    flit_o[PktSrcXLsb +: 4]  = src_x_i;
    flit_o[PktSrcYLsb +: 4]  = src_y_i;
    flit_o[PktIdxLsb +: 8]   = idx_i;
    flit_o[PktTsLsb +: 8]    = ts_i;
  end

endmodule

// File: rtl/timestep_scheduler.sv
// Per-node SNN timestep sequencer: sweeps the neuron bank (update, read spike
// flag) and injects one spike flit per firing neuron into the router local port.
module timestep_scheduler
  import timestep_scheduler_pkg::*;
#(
  parameter int unsigned NUM_NEURONS   = 4,
  parameter int unsigned ADDR_X        = 0,
  parameter int unsigned ADDR_Y        = 0,
  parameter logic [31:0] NBANK_BASE    = 32'h0000_1000,
  parameter logic [31:0] NEURON_STRIDE = 32'h10,
  parameter logic [31:0] STEP_OFF      = DefaultStepOff,
  parameter logic [31:0] SPIKE_OFF     = DefaultSpikeOff
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  cfg_dest_x,
  input  logic [3:0]  cfg_dest_y,
  input  logic        cpu_req,
  output logic        cpu_hold,
  output logic [31:0] nb_addr,
  output logic        nb_write_en,
  output logic [31:0] nb_write_data,
  output logic        nb_read_en,
  input  logic [31:0] nb_read_data,
  input  logic        nb_busywait,
  output logic [31:0] pkt_data,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [15:0] timestep
);

  localparam logic [7:0] LastIdx = 8'(NUM_NEURONS - 1);
  localparam logic [3:0] SrcX    = 4'(ADDR_X);
  localparam logic [3:0] SrcY    = 4'(ADDR_Y);

  sched_state_e state_q, state_d;
  logic [7:0]   idx_q, idx_d;
  logic [15:0]  timestep_q, timestep_d;
  logic         overrun_q, overrun_d;
  logic [3:0]   dest_x_q, dest_x_d;
  logic [3:0]   dest_y_q, dest_y_d;
  logic [31:0]  flit;
  logic         last_neuron;
  logic         unused_rd;

  assign unused_rd   = ^nb_read_data[31:1];
  assign last_neuron = (idx_q == LastIdx);

  timestep_scheduler_spike_pkt_builder u_pkt_builder (
    .dest_x_i (dest_x_q),
    .dest_y_i (dest_y_q),
    .src_x_i  (SrcX),
    .src_y_i  (SrcY),
    .idx_i    (idx_q),
    .ts_i     (timestep_q[7:0]),
    .flit_o   (flit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      timestep_q <= '0;
      overrun_q  <= 1'b0;
      dest_x_q   <= '0;
      dest_y_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      timestep_q <= timestep_d;
      overrun_q  <= overrun_d;
      dest_x_q   <= dest_x_d;
      dest_y_q   <= dest_y_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    timestep_d    = timestep_q;
    overrun_d     = overrun_q;
    dest_x_d      = dest_x_q;
    dest_y_d      = dest_y_q;
    nb_addr       = '0;
    nb_write_en   = 1'b0;
    nb_write_data = '0;
    nb_read_en    = 1'b0;
    pkt_data      = '0;
    pkt_valid     = 1'b0;
    done          = 1'b0;

    // Any start outside IDLE (DONE included) is dropped and flagged.
    if (start && (state_q != StIdle)) overrun_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          overrun_d = 1'b0;
          idx_d     = '0;
          state_d   = cpu_req ? StWaitBus : StUpdate;
        end
      end
      StWaitBus: begin
        if (!cpu_req) state_d = StUpdate;
      end
      StUpdate: begin
        nb_write_en   = 1'b1;
        nb_write_data = 32'h1;
        nb_addr       = neuron_addr(NBANK_BASE, NEURON_STRIDE, idx_q, STEP_OFF);
        if (!nb_busywait) state_d = StRead;
      end
      StRead: begin
        nb_read_en = 1'b1;
        nb_addr    = neuron_addr(NBANK_BASE, NEURON_STRIDE, idx_q, SPIKE_OFF);
        if (!nb_busywait) begin
          if (nb_read_data[0]) begin
            // Destination is latched as the flit goes valid so it stays stable.
            dest_x_d = cfg_dest_x;
            dest_y_d = cfg_dest_y;
            state_d  = StSend;
          end else if (last_neuron) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = StUpdate;
          end
        end
      end
      StSend: begin
        pkt_valid = 1'b1;
        pkt_data  = flit;
        if (pkt_ready) begin
          if (last_neuron) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = StUpdate;
          end
        end
      end
      StDone: begin
        done       = 1'b1;
        timestep_d = timestep_q + 16'd1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign cpu_hold = (state_q != StIdle) && (state_q != StWaitBus);
  assign overrun  = overrun_q;
  assign timestep = timestep_q;

endmodule

// File: tb/tb_timestep_scheduler.sv
// Directed bench for timestep_scheduler with a small neuron-bank / router model.
module tb_timestep_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  cfg_dest_x, cfg_dest_y;
  logic        cpu_req;
  logic        cpu_hold;
  logic [31:0] nb_addr;
  logic        nb_write_en;
  logic [31:0] nb_write_data;
  logic        nb_read_en;
  logic [31:0] nb_read_data;
  logic        nb_busywait;
  logic [31:0] pkt_data;
  logic        pkt_valid;
  logic        pkt_ready;
  logic        busy, done, overrun;
  logic [15:0] timestep;

  timestep_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_dest_x    (cfg_dest_x),
    .cfg_dest_y    (cfg_dest_y),
    .cpu_req       (cpu_req),
    .cpu_hold      (cpu_hold),
    .nb_addr       (nb_addr),
    .nb_write_en   (nb_write_en),
    .nb_write_data (nb_write_data),
    .nb_read_en    (nb_read_en),
    .nb_read_data  (nb_read_data),
    .nb_busywait   (nb_busywait),
    .pkt_data      (pkt_data),
    .pkt_valid     (pkt_valid),
    .pkt_ready     (pkt_ready),
    .busy          (busy),
    .done          (done),
    .overrun       (overrun),
    .timestep      (timestep)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    int          w;
    int          r;
    logic [3:0]  dx;
    logic [3:0]  dy;
    int          req;
    int          dup;
    int          exp_cyc;
    logic [31:0] pkt0;
  } vec_t;

  vec_t vecs[10];

  int n_checks = 0;
  int n_pass   = 0;

  // Bank / router model state
  logic [3:0]  cur_mask = '0;
  int          cur_w = 0, cur_r = 0;
  logic [3:0]  cur_dx = '0, cur_dy = '0;
  logic [31:0] cur_pkt0 = '0;
  logic [15:0] exp_ts = '0;
  int          acc_k = 0, pkt_k = 0, vcnt = 0, acc_cyc = 0;
  logic        acc_open = 1'b0, acc_we = 1'b0;
  logic [31:0] acc_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] nth_spike(input logic [3:0] m, input int k);
    int c;
    c = 0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        if (c == k) return 8'(i);
        c++;
      end
    end
    return 8'hFF;
  endfunction

  // Respond as bank and router for the current cycle, checking bus behaviour.
  task automatic model();
    logic        strobe;
    logic [31:0] nidx, exp_addr, good;
    strobe = nb_write_en | nb_read_en;
    if (acc_open) chk("strobe_held", strobe, 1);
    if (strobe) begin
      chk("one_strobe", nb_write_en & nb_read_en, 0);
      if (acc_open) begin
        chk("strobe_stable", {nb_write_en, nb_addr}, {acc_we, acc_addr});
      end else begin
        acc_open = 1'b1;
        acc_cyc  = 0;
        acc_addr = nb_addr;
        acc_we   = nb_write_en;
      end
      acc_cyc++;
      nb_busywait = (acc_cyc <= cur_w);
      nidx = (nb_addr - 32'h1000) >> 4;
      good = {31'h0, (nidx < 4) ? cur_mask[nidx[1:0]] : 1'b0};
      nb_read_data = nb_busywait ? ~good : good;
      if (!nb_busywait) begin
        exp_addr = 32'h1000 + 32'(acc_k >> 1) * 32'h10 + ((acc_k % 2 == 1) ? 32'h4 : 32'h0);
        chk("access", {nb_write_en, nb_addr}, {(acc_k % 2 == 0), exp_addr});
        if (nb_write_en) chk("write_data", nb_write_data, 1);
        acc_k++;
        acc_open = 1'b0;
      end
    end else begin
      nb_busywait  = 1'b0;
      nb_read_data = '0;
      acc_open     = 1'b0;
    end

    if (pkt_valid) begin
      chk("pkt_data", pkt_data,
          {cur_dx, cur_dy, 8'h00, nth_spike(cur_mask, pkt_k), exp_ts[7:0]});
      if (pkt_k == 0) chk("pkt_table", pkt_data, cur_pkt0);
      pkt_ready = (vcnt >= cur_r);
      if (pkt_ready) begin
        pkt_k++;
        vcnt       = 0;
        cfg_dest_x = cur_dx;
        cfg_dest_y = cur_dy;
      end else begin
        // Scramble config while the flit waits: it must already be latched.
        vcnt++;
        cfg_dest_x = ~cur_dx;
        cfg_dest_y = ~cur_dy;
      end
    end else begin
      pkt_ready  = 1'b0;
      cfg_dest_x = cur_dx;
      cfg_dest_y = cur_dy;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model();
  endtask

  task automatic run_sweep(input int req, input int dup, input int exp_cyc, input logic exp_ovr);
    int cyc;
    acc_k    = 0;
    pkt_k    = 0;
    vcnt     = 0;
    acc_open = 1'b0;
    start    = 1'b1;
    cpu_req  = (req > 0);
    cycle();
    start = 1'b0;
    cyc   = 1;
    if (req == 0) chk("overrun_clear", overrun, 0);
    while (1) begin
      cpu_req = (cyc < req);
      start   = (dup != 0) && (cyc == dup);
      if (cyc <= req) chk("wait_bus", {busy, cpu_hold, nb_write_en, nb_read_en}, 4'b1000);
      else chk("hold", {busy, cpu_hold}, 2'b11);
      if (cyc == req + 1) chk("first_update", {nb_write_en, nb_addr}, {1'b1, 32'h1000});
      if (done || cyc >= 400) break;
      cycle();
      cyc++;
    end
    chk("cycles", cyc, exp_cyc);
    chk("done_seen", done, 1);
    exp_ts = exp_ts + 16'd1;
    chk("access_count", acc_k, 8);
    chk("pkt_count", pkt_k, $countones(cur_mask));
    cycle();
    start = 1'b0;
    chk("idle", {busy, cpu_hold, done, pkt_valid, nb_write_en, nb_read_en}, 0);
    chk("timestep", timestep, exp_ts);
    chk("overrun", overrun, exp_ovr);
    cycle();
    chk("no_restart", busy, 0);
  endtask

  initial begin
    //          mask     w  r  dx     dy     req dup cyc pkt0
    vecs[0] = '{4'b0000, 0, 0, 4'h0, 4'h0, 0, 0, 9,  32'h0};
    vecs[1] = '{4'b0000, 2, 0, 4'h0, 4'h0, 0, 0, 25, 32'h0};
    vecs[2] = '{4'b1001, 0, 0, 4'h0, 4'h0, 0, 0, 11, 32'h0000_0002};
    vecs[3] = '{4'b1111, 0, 1, 4'h1, 4'h2, 0, 0, 17, 32'h1200_0003};
    vecs[4] = '{4'b0010, 2, 0, 4'hF, 4'h7, 0, 0, 26, 32'hF700_0104};
    vecs[5] = '{4'b0100, 0, 3, 4'h3, 4'h1, 0, 0, 13, 32'h3100_0205};
    vecs[6] = '{4'b0000, 0, 0, 4'h0, 4'h0, 4, 0, 13, 32'h0};
    vecs[7] = '{4'b1000, 1, 2, 4'h2, 4'h9, 2, 0, 22, 32'h2900_0307};
    vecs[8] = '{4'b0000, 0, 0, 4'h0, 4'h0, 0, 3, 9,  32'h0};
    vecs[9] = '{4'b0000, 0, 0, 4'h0, 4'h0, 0, 9, 9,  32'h0};

    rst          = 1'b0;
    start        = 1'b0;
    cpu_req      = 1'b0;
    cfg_dest_x   = '0;
    cfg_dest_y   = '0;
    nb_read_data = '0;
    nb_busywait  = 1'b0;
    pkt_ready    = 1'b0;
    #12;
    chk("reset_ctrl", {cpu_hold, nb_write_en, nb_read_en, pkt_valid, busy, done, overrun}, 0);
    chk("reset_bus", {nb_addr, nb_write_data}, 0);
    chk("reset_pkt", pkt_data, 0);
    chk("reset_ts", timestep, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle();

    for (int v = 0; v < 10; v++) begin
      cur_mask = vecs[v].mask;
      cur_w    = vecs[v].w;
      cur_r    = vecs[v].r;
      cur_dx   = vecs[v].dx;
      cur_dy   = vecs[v].dy;
      cur_pkt0 = vecs[v].pkt0;
      run_sweep(vecs[v].req, vecs[v].dup, vecs[v].exp_cyc, vecs[v].dup != 0);
    end

    // Reset while a flit is stalled in SEND
    cur_mask = 4'b0001;
    cur_w    = 0;
    cur_r    = 1000;
    cur_dx   = 4'h5;
    cur_dy   = 4'h6;
    cur_pkt0 = {4'h5, 4'h6, 8'h00, 8'h00, exp_ts[7:0]};
    acc_k    = 0;
    pkt_k    = 0;
    vcnt     = 0;
    start    = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 10 && !pkt_valid; i++) cycle();
    chk("send_reached", pkt_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_ctrl", {cpu_hold, nb_write_en, nb_read_en, pkt_valid, busy, done, overrun}, 0);
    chk("async_rst_bus", {nb_addr, nb_write_data}, 0);
    chk("async_rst_pkt", pkt_data, 0);
    chk("async_rst_ts", timestep, 0);
    exp_ts = '0;
    cycle();
    rst = 1'b1;
    cycle();
    cycle();
    chk("post_rst_idle", {busy, pkt_valid}, 0);

    // Timestep wrap: preset counter to its maximum then run one spiking sweep
    force dut.timestep_q = 16'hFFFF;
    cycle();
    release dut.timestep_q;
    cycle();
    chk("preset", timestep, 16'hFFFF);
    exp_ts   = 16'hFFFF;
    cur_mask = 4'b0001;
    cur_w    = 0;
    cur_r    = 0;
    cur_dx   = 4'hA;
    cur_dy   = 4'hB;
    cur_pkt0 = 32'hAB00_00FF;
    run_sweep(0, 0, 10, 1'b0);
    chk("wrapped", timestep, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
